io_tx_fsm: RTL
==============

IO_TX_FSM -- requirements
Module: io_tx_fsm

Interface
REQ-001 clk  input  1  single clock; all state changes on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ready  input  1  coordinator finished; results are available to transmit.
REQ-004 byte_in  input  8  result byte from the result producer.
REQ-005 byte_valid  input  1  byte_in valid this cycle.
REQ-006 byte_last  input  1  qualifies byte_in as last byte of the result object.
REQ-007 byte_req  output  1  block accepts a byte this cycle; a byte transfers when byte_valid & byte_req.
REQ-008 data_out  output  32  packed word; lane0 [7:0]=A, lane1 [15:8]=B, lane2 [23:16]=U, lane3 [31:24]=control/rest.
REQ-009 int  output  1  word pending on data_out for the host.
REQ-010 ack  input  1  host consumed the pending word.
REQ-011 eob  output  1  pending word is the last word of the object.
REQ-012 nbytes  output  3  valid byte count in pending word, 1..4.
REQ-013 word_count  output  8  words acknowledged since leaving IDLE, wraps modulo 256.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last word is acknowledged.

Function
REQ-016 States: IDLE, PACK, SEND, DONE; 2-bit state register plus 2-bit lane counter cnt.
REQ-017 IDLE: byte_req=int=eob=done=0; ready=1 -> PACK next cycle, word_count cleared to 0, cnt=0, shadow word cleared to 0.
REQ-018 PACK: byte_req=1, int=0; an accepted byte is written to lane cnt and cnt increments (2-bit wrap).
REQ-019 PACK: accepted byte with cnt==3 or byte_last=1 -> SEND next cycle; nbytes=cnt+1 and eob=byte_last are latched.
REQ-020 Lanes not written in a partial word SHALL read 0 on data_out.
REQ-021 Latency: byte accepted at edge N -> int=1 and data_out valid from edge N+1 onward.
REQ-022 SEND: int=1, byte_req=0; data_out, nbytes and eob held stable until ack.
REQ-023 SEND with ack=1: word_count increments; eob=1 -> DONE, else -> PACK with cnt=0 and shadow cleared.
REQ-024 DONE: done=1 for exactly one cycle; busy=1; next state IDLE; int=0.
REQ-025 byte_valid while byte_req=0 is ignored; no byte is lost or duplicated.
REQ-026 ack outside SEND is ignored; ready outside IDLE is ignored.
REQ-027 byte_last on first byte (cnt==0) yields a 1-byte word, nbytes=1.
REQ-028 byte_last with cnt==3 yields a full word with eob=1, nbytes=4.
REQ-029 byte_valid without byte_last keeps packing across unlimited words; word_count wraps 255->0 without stalling.

Reset
REQ-030 reset=1 at posedge: state=IDLE, cnt=0, data_out=0, nbytes=0, word_count=0, int=byte_req=eob=done=busy=0.
REQ-031 Reset asserted mid-PACK or mid-SEND SHALL abandon the word without an ack; no done pulse is generated.
REQ-032 reset has priority over ready, ack and byte_valid in the same cycle.

Structure
REQ-033 Shared package io_pkg holds the state encodings IDLE=2'b00, PACK=2'b01, SEND=2'b10, DONE=2'b11 and the constants LANE_W=8, WORD_W=32, LANES=4.
REQ-034 One sub-module io_word_packer (4x8 lane register, lane-write enable by cnt, clear); FSM, counters and handshake stay in io_tx_fsm.

Verification
REQ-035 ready pulse, bytes 11,22,33,44 with byte_last on 44 -> int=1 one cycle after 44, data_out=0x44332211, nbytes=4, eob=1; ack -> done pulse, IDLE.
REQ-036 bytes AA,BB,CC,DD,EE (last on EE) -> word1 0xDDCCBBAA nbytes=4 eob=0; after ack word2 0x000000EE nbytes=1 eob=1; word_count=2.
REQ-037 byte_valid held high during SEND with byte 0x55 -> not accepted; after ack 0x55 lands in lane0 of the next word.
REQ-038 Host delays ack 10 cycles -> data_out/nbytes/eob unchanged across all 10, byte_req=0 throughout.
REQ-039 reset after 2 bytes in PACK -> all outputs zero next cycle, no done; fresh ready + byte 0x7F last -> 0x0000007F, nbytes=1.
REQ-040 257 full words without byte_last, each acked -> word_count=1 after the 257th ack, no stall.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and constants for the result transmitter: FSM state encodings
// and the word/lane geometry used by the packer and the host interface.
package io_pkg;

    localparam int LANE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PACK = 2'b01,
        SEND = 2'b10,
        DONE = 2'b11
    } state_t;

    // Number of valid bytes in a word whose last byte went into lane cnt.
    function automatic logic [2:0] lane_count(input logic [CNT_W-1:0] cnt);
        return {1'b0, cnt} + 3'd1;
    endfunction

endpackage

// File: rtl/io_tx_fsm_if.sv
// Bundle of the byte-stream input, host word output and status signals of io_tx_fsm.
// The host interrupt line is called intr because int is a reserved word.
interface io_tx_fsm_if;
    import io_pkg::*;

    logic              ready;
    logic [LANE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_req;
    logic [WORD_W-1:0] data_out;
    logic              intr;
    logic              ack;
    logic              eob;
    logic [2:0]        nbytes;
    logic [7:0]        word_count;
    logic              busy;
    logic              done;

    // master is the transmitter block; slave is the producer/host side.
    modport master (
        input  ready, byte_in, byte_valid, byte_last, ack,
        output byte_req, data_out, intr, eob, nbytes, word_count, busy, done
    );

    modport slave (
        output ready, byte_in, byte_valid, byte_last, ack,
        input  byte_req, data_out, intr, eob, nbytes, word_count, busy, done
    );

endinterface

// File: rtl/io_word_packer.sv
// Four-lane shadow register that assembles result bytes into a 32-bit word.
// Unwritten lanes stay zero because every new word starts from a clear.
module io_word_packer
    import io_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  lane,
    input  logic [LANE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word
);

    logic [LANE_W-1:0] lanes [LANES];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < LANES; i++) begin
                lanes[i] <= '0;
            end
        end else if (wr_en) begin
            lanes[lane] <= byte_in;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            word[i*LANE_W +: LANE_W] = lanes[i];
        end
    end

endmodule

// File: rtl/io_tx_fsm.sv
// Result transmitter: packs bytes from the result producer into 32-bit words
// and hands each word to the host with an int/ack handshake.
module io_tx_fsm
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    io_tx_fsm_if.master bus
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        nbytes_q;
    logic              eob_q;
    logic [7:0]        word_count_q;
    logic [WORD_W-1:0] word;

    logic accept;
    logic word_end;
    logic pack_clear;

    assign accept     = (state == PACK) && bus.byte_valid;
    assign word_end   = accept && ((cnt == 2'd3) || bus.byte_last);
    assign pack_clear = ((state == IDLE) && bus.ready)
                     || ((state == SEND) && bus.ack && !eob_q);

    io_word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (pack_clear),
        .wr_en   (accept),
        .lane    (cnt),
        .byte_in (bus.byte_in),
        .word    (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.ready) state_next = PACK;
            PACK: if (word_end)  state_next = SEND;
            SEND: if (bus.ack)   state_next = eob_q ? DONE : PACK;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane counter, latched word attributes and the acknowledged-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            nbytes_q     <= '0;
            eob_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ready) begin
                        cnt          <= '0;
                        word_count_q <= '0;
                    end
                end
                PACK: begin
                    if (accept) begin
                        cnt <= cnt + 2'd1;
                    end
                    if (word_end) begin
                        nbytes_q <= lane_count(cnt);
                        eob_q    <= bus.byte_last;
                    end
                end
                SEND: begin
                    if (bus.ack) begin
                        word_count_q <= word_count_q + 8'd1;
                        if (!eob_q) begin
                            cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.byte_req   = (state == PACK);
        bus.intr       = (state == SEND);
        bus.eob        = (state == SEND) && eob_q;
        bus.done       = (state == DONE);
        bus.busy       = (state != IDLE);
        bus.data_out   = word;
        bus.nbytes     = nbytes_q;
        bus.word_count = word_count_q;
    end

endmodule
